// File: rtl/color_filter_req_master.sv
// color_filter_req_master
//
// Initiator side of the four-phase req/ack pixel handshake for the colour-threshold
// filter. RGB565 pixels from the capture stream are presented one at a time on
// sensor_data/req_out. The filter's 1-bit match result is collected per pixel, and
// results are packed into 16-bit mask words (bit0 = earliest pixel). A per-frame
// match count and bounding box are published on frame_done.
//
// Optional build macro: TIMEOUT_EN. When defined, each handshake phase is bounded
// by TIMEOUT_CYC cycles. On expiry the pixel is recorded as 0 and the sticky
// timeout_err flag is set. When undefined, the FSM waits indefinitely and
// timeout_err is tied 0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pix_valid/pix_data    upstream RGB565 pixel stream
//   pix_ready             high only when idle (ready to accept a pixel)
//   req_out/sensor_data   request and held pixel to the filter
//   ack_in/color_in       filter acknowledge (async domain) and match bit
//   mask_valid/mask_word  one-cycle pulse with a packed 16-bit match word
//   frame_done            one-cycle pulse after the last pixel of a frame
//   hit_count, bbox_valid, x_min, x_max, y_min, y_max
//                         results of the last completed frame
//   timeout_err           sticky handshake timeout flag
module color_filter_req_master #(
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        req_out,
    output logic [15:0] sensor_data,
    input  logic        ack_in,
    input  logic        color_in,
    output logic        mask_valid,
    output logic [15:0] mask_word,
    output logic        frame_done,
    output logic [19:0] hit_count,
    output logic        bbox_valid,
    output logic [10:0] x_min,
    output logic [10:0] x_max,
    output logic [9:0]  y_min,
    output logic [9:0]  y_max,
    output logic        timeout_err
);

    localparam logic [10:0] XLast = 11'(H_RES - 1);
    localparam logic [9:0]  YLast = 10'(V_RES - 1);

    typedef enum logic [1:0] {StIdle, StWaitAckHi, StWaitAckLo} state_e;

    state_e      state_q, state_d;
    logic        ack_meta_q, ack_s;
    logic        req_q, req_d;
    logic [15:0] sensor_q, sensor_d;
    logic        color_q, color_d;
    logic        ready_q, ready_d;
    logic        do_update, upd_bit;
    logic        tmo_hit;

    // Running frame state
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] acc_q, acc_d;
    logic [19:0] cnt_q, cnt_d;
    logic [10:0] rx_min_q, rx_min_d, rx_max_q, rx_max_d;
    logic [9:0]  ry_min_q, ry_min_d, ry_max_q, ry_max_d;

    // Published outputs
    logic        mvalid_q, mvalid_d;
    logic [15:0] mword_q, mword_d;
    logic        fdone_q, fdone_d;
    logic [19:0] hits_q, hits_d;
    logic        bvalid_q, bvalid_d;
    logic [10:0] ox_min_q, ox_min_d, ox_max_q, ox_max_d;
    logic [9:0]  oy_min_q, oy_min_d, oy_max_q, oy_max_d;

    // Two-flop synchroniser for the acknowledge from the filter's clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta_q <= 1'b0;
            ack_s      <= 1'b0;
        end else begin
            ack_meta_q <= ack_in;
            ack_s      <= ack_meta_q;
        end
    end

`ifdef TIMEOUT_EN
    logic [15:0] tmo_q;
    logic        tmo_err_q;

    assign tmo_hit     = (state_q != StIdle) && (tmo_q == 16'(TIMEOUT_CYC - 1));
    assign timeout_err = tmo_err_q;

    // Counts cycles spent in the current wait phase; any state change restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                tmo_q <= '0;
            end else if (state_q != StIdle) begin
                tmo_q <= tmo_q + 16'd1;
            end
            if (tmo_hit) begin
                tmo_err_q <= 1'b1;
            end
        end
    end
`else
    // TIMEOUT_CYC only matters when the timeout is built in.
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign tmo_hit            = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    // Handshake FSM
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        sensor_d  = sensor_q;
        color_d   = color_q;
        do_update = 1'b0;
        upd_bit   = color_q;
        case (state_q)
            StIdle: begin
                if (pix_valid && ready_q) begin
                    sensor_d = pix_data;
                    req_d    = 1'b1;
                    state_d  = StWaitAckHi;
                end
            end
            StWaitAckHi: begin
                // A stale ack still high on entry is accepted as the answer.
                if (ack_s) begin
                    color_d = color_in;
                    req_d   = 1'b0;
                    state_d = StWaitAckLo;
                end else if (tmo_hit) begin
                    req_d     = 1'b0;
                    do_update = 1'b1;
                    upd_bit   = 1'b0;
                    state_d   = StIdle;
                end
            end
            StWaitAckLo: begin
                if (!ack_s) begin
                    do_update = 1'b1;
                    state_d   = StIdle;
                end else if (tmo_hit) begin
                    do_update = 1'b1;
                    upd_bit   = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = StIdle;
            end
        endcase
        // Registered so that pix_ready is 0 while reset is asserted.
        ready_d = (state_d == StIdle);
    end

    // Per-pixel bookkeeping: mask packing, hit statistics and raster position.
    logic        last_x, frame_end;
    logic [15:0] word;
    logic [19:0] cnt_n;
    logic [10:0] rx_min_n, rx_max_n;
    logic [9:0]  ry_min_n, ry_max_n;

    always_comb begin
        last_x    = (x_q == XLast);
        frame_end = last_x && (y_q == YLast);

        word          = acc_q;
        word[idx_q]   = upd_bit;

        cnt_n    = cnt_q;
        rx_min_n = rx_min_q;
        rx_max_n = rx_max_q;
        ry_min_n = ry_min_q;
        ry_max_n = ry_max_q;
        if (upd_bit) begin
            if (cnt_q != '1) begin
                cnt_n = cnt_q + 20'd1;
            end
            if (x_q < rx_min_q) rx_min_n = x_q;
            if (x_q > rx_max_q) rx_max_n = x_q;
            if (y_q < ry_min_q) ry_min_n = y_q;
            if (y_q > ry_max_q) ry_max_n = y_q;
        end

        x_d      = x_q;
        y_d      = y_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        rx_min_d = rx_min_q;
        rx_max_d = rx_max_q;
        ry_min_d = ry_min_q;
        ry_max_d = ry_max_q;
        mvalid_d = 1'b0;
        mword_d  = mword_q;
        fdone_d  = 1'b0;
        hits_d   = hits_q;
        bvalid_d = bvalid_q;
        ox_min_d = ox_min_q;
        ox_max_d = ox_max_q;
        oy_min_d = oy_min_q;
        oy_max_d = oy_max_q;

        if (do_update) begin
            // The accumulator is cleared on every emit, so a partial word flushed
            // at frame end has its unused high bits at 0.
            if (idx_q == 4'd15 || frame_end) begin
                mword_d  = word;
                mvalid_d = 1'b1;
                acc_d    = '0;
                idx_d    = '0;
            end else begin
                acc_d = word;
                idx_d = idx_q + 4'd1;
            end

            x_d      = last_x ? 11'd0 : x_q + 11'd1;
            y_d      = last_x ? y_q + 10'd1 : y_q;
            cnt_d    = cnt_n;
            rx_min_d = rx_min_n;
            rx_max_d = rx_max_n;
            ry_min_d = ry_min_n;
            ry_max_d = ry_max_n;

            if (frame_end) begin
                hits_d   = cnt_n;
                bvalid_d = (cnt_n != '0);
                ox_min_d = rx_min_n;
                ox_max_d = rx_max_n;
                oy_min_d = ry_min_n;
                oy_max_d = ry_max_n;
                fdone_d  = 1'b1;
                cnt_d    = '0;
                rx_min_d = XLast;
                rx_max_d = '0;
                ry_min_d = YLast;
                ry_max_d = '0;
                y_d      = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            req_q    <= 1'b0;
            sensor_q <= '0;
            color_q  <= 1'b0;
            ready_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            rx_min_q <= XLast;
            rx_max_q <= '0;
            ry_min_q <= YLast;
            ry_max_q <= '0;
            mvalid_q <= 1'b0;
            mword_q  <= '0;
            fdone_q  <= 1'b0;
            hits_q   <= '0;
            bvalid_q <= 1'b0;
            ox_min_q <= '0;
            ox_max_q <= '0;
            oy_min_q <= '0;
            oy_max_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            sensor_q <= sensor_d;
            color_q  <= color_d;
            ready_q  <= ready_d;
            x_q      <= x_d;
            y_q      <= y_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            rx_min_q <= rx_min_d;
            rx_max_q <= rx_max_d;
            ry_min_q <= ry_min_d;
            ry_max_q <= ry_max_d;
            mvalid_q <= mvalid_d;
            mword_q  <= mword_d;
            fdone_q  <= fdone_d;
            hits_q   <= hits_d;
            bvalid_q <= bvalid_d;
            ox_min_q <= ox_min_d;
            ox_max_q <= ox_max_d;
            oy_min_q <= oy_min_d;
            oy_max_q <= oy_max_d;
        end
    end

    assign pix_ready   = ready_q;
    assign req_out     = req_q;
    assign sensor_data = sensor_q;
    assign mask_valid  = mvalid_q;
    assign mask_word   = mword_q;
    assign frame_done  = fdone_q;
    assign hit_count   = hits_q;
    assign bbox_valid  = bvalid_q;
    assign x_min       = ox_min_q;
    assign x_max       = ox_max_q;
    assign y_min       = oy_min_q;
    assign y_max       = oy_max_q;

endmodule

// File: tb/tb_color_filter_req_master.sv
// Self-checking bench for color_filter_req_master on a small 8x4 frame.
// The bench plays the filter responder inline and predicts masks and frame
// statistics from raster position arithmetic.
module tb_color_filter_req_master;

    localparam int H     = 8;
    localparam int V     = 4;
    localparam int TCYC  = 20;
    localparam int BOUND = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_data = '0;
    logic        pix_ready;
    logic        req_out;
    logic [15:0] sensor_data;
    logic        ack_in = 1'b0;
    logic        color_in = 1'b0;
    logic        mask_valid;
    logic [15:0] mask_word;
    logic        frame_done;
    logic [19:0] hit_count;
    logic        bbox_valid;
    logic [10:0] x_min, x_max;
    logic [9:0]  y_min, y_max;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    color_filter_req_master #(
        .H_RES      (H),
        .V_RES      (V),
        .TIMEOUT_CYC(TCYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .req_out    (req_out),
        .sensor_data(sensor_data),
        .ack_in     (ack_in),
        .color_in   (color_in),
        .mask_valid (mask_valid),
        .mask_word  (mask_word),
        .frame_done (frame_done),
        .hit_count  (hit_count),
        .bbox_valid (bbox_valid),
        .x_min      (x_min),
        .x_max      (x_max),
        .y_min      (y_min),
        .y_max      (y_max),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] cnt;
        logic        bv;
        logic [10:0] xmn, xmx;
        logic [9:0]  ymn, ymx;
    } frame_t;

    // Observed pulses
    logic [15:0] mask_seen[$];
    frame_t      frame_seen[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (mask_valid) mask_seen.push_back(mask_word);
            if (frame_done) frame_seen.push_back('{hit_count, bbox_valid, x_min, x_max, y_min, y_max});
        end
    end

    // Reference model: pixel n of a frame sits at (n % H, n / H)
    int          pix_idx;
    bit          cur_bits[$];
    int          hit_x[$], hit_y[$];
    logic [15:0] exp_mask[$];
    frame_t      exp_frame[$];

    function automatic void model_reset();
        pix_idx = 0;
        cur_bits.delete();
        hit_x.delete();
        hit_y.delete();
        exp_mask.delete();
        exp_frame.delete();
        mask_seen.delete();
        frame_seen.delete();
    endfunction

    function automatic void model_pixel(bit b);
        int x = pix_idx % H;
        int y = pix_idx / H;
        cur_bits.push_back(b);
        if (b) begin
            hit_x.push_back(x);
            hit_y.push_back(y);
        end
        if (cur_bits.size() == 16 || pix_idx == H * V - 1) begin
            logic [15:0] w = '0;
            foreach (cur_bits[i]) w[i] = cur_bits[i];
            exp_mask.push_back(w);
            cur_bits.delete();
        end
        if (pix_idx == H * V - 1) begin
            frame_t f;
            f.cnt = 20'(hit_x.size());
            f.bv  = (hit_x.size() != 0);
            f.xmn = 11'(H - 1);
            f.xmx = '0;
            f.ymn = 10'(V - 1);
            f.ymx = '0;
            foreach (hit_x[i]) begin
                if (hit_x[i] < int'(f.xmn)) f.xmn = 11'(hit_x[i]);
                if (hit_x[i] > int'(f.xmx)) f.xmx = 11'(hit_x[i]);
                if (hit_y[i] < int'(f.ymn)) f.ymn = 10'(hit_y[i]);
                if (hit_y[i] > int'(f.ymx)) f.ymx = 10'(hit_y[i]);
            end
            exp_frame.push_back(f);
            hit_x.delete();
            hit_y.delete();
            pix_idx = 0;
        end else begin
            pix_idx++;
        end
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        ack_in    = 1'b0;
        color_in  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    // One full pixel transaction with the bench acting as the filter.
    task automatic do_pixel(input logic [15:0] d, input bit c, input int dly);
        int n;
        bit ok;
        n = 0;
        while (!pix_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        pix_data  = d;
        pix_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_out && n < BOUND);
        pix_valid = 1'b0;
        pix_data  = 16'($urandom);
        checks++;
        if (req_out !== 1'b1) begin
            errors++;
            $display("FAIL accept: req_out=%b required 1", req_out);
            return;
        end
        ok = 1'b1;
        for (int i = 0; i < dly; i++) begin
            if (req_out !== 1'b1 || sensor_data !== d) ok = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!ok || sensor_data !== d) begin
            errors++;
            $display("FAIL sensor_hold: sensor_data=%h required %h while req_out=1", sensor_data, d);
        end
        ack_in   = 1'b1;
        color_in = c;
        n  = 0;
        ok = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (pix_ready) ok = 1'b0;
        end while (req_out && n < BOUND);
        checks++;
        if (n > 3 || req_out !== 1'b0) begin
            errors++;
            $display("FAIL req_fall: req_out fell after %0d cycles, required <=3", n);
        end
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            if (pix_ready) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ready_during_ack: pix_ready=1 seen, required 0 while ack high");
        end
        ack_in   = 1'b0;
        color_in = 1'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pix_ready && n < BOUND);
        checks++;
        if (n < 3 || pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_return: pix_ready=%b after %0d cycles, required 1 after >=3",
                     pix_ready, n);
        end
        model_pixel(c);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({pix_ready, req_out, mask_valid, frame_done, bbox_valid, timeout_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: %b required 000000",
                     {pix_ready, req_out, mask_valid, frame_done, bbox_valid, timeout_err});
        end
        checks++;
        if (sensor_data !== 16'h0 || mask_word !== 16'h0 || hit_count !== 20'h0) begin
            errors++;
            $display("FAIL reset_data: sensor=%h mask=%h hits=%h required 0",
                     sensor_data, mask_word, hit_count);
        end
        checks++;
        if (x_min !== 11'd0 || x_max !== 11'd0 || y_min !== 10'd0 || y_max !== 10'd0) begin
            errors++;
            $display("FAIL reset_bbox: %0d %0d %0d %0d required 0 0 0 0", x_min, x_max, y_min, y_max);
        end
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (pix_ready !== 1'b1 || req_out !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: pix_ready=%b req_out=%b required 1 0", pix_ready, req_out);
        end
    endtask

    task automatic test_single_pixel();
        do_pixel(16'hF800, 1'b1, 5);
        repeat (2) @(negedge clk);
        checks++;
        if (mask_seen.size() != 0 || frame_seen.size() != 0) begin
            errors++;
            $display("FAIL single_no_pulse: masks=%0d frames=%0d required 0 0",
                     mask_seen.size(), frame_seen.size());
        end
    endtask

    task automatic test_mask();
        apply_reset();
        for (int i = 0; i < 16; i++) do_pixel(16'($urandom), (i % 2 == 0), $urandom_range(0, 6));
        repeat (2) @(negedge clk);
        checks++;
        if (mask_seen.size() != 1) begin
            errors++;
            $display("FAIL mask_count: %0d pulses required 1", mask_seen.size());
        end else begin
            checks++;
            if (mask_seen[0] !== 16'h5555) begin
                errors++;
                $display("FAIL mask_word: %h required 5555", mask_seen[0]);
            end
        end
    endtask

    task automatic test_frame();
        apply_reset();
        for (int i = 0; i < H * V; i++) do_pixel(16'($urandom), (i == 1 * H + 2) || (i == 3 * H + 5), 1);
        repeat (2) @(negedge clk);
        checks++;
        if (frame_seen.size() != 1) begin
            errors++;
            $display("FAIL frame_count: %0d frame_done pulses required 1", frame_seen.size());
        end else begin
            checks++;
            if (frame_seen[0].cnt !== 20'd2 || frame_seen[0].bv !== 1'b1) begin
                errors++;
                $display("FAIL frame_hits: count=%0d valid=%b required 2 1",
                         frame_seen[0].cnt, frame_seen[0].bv);
            end
            checks++;
            if (frame_seen[0].xmn !== 11'd2 || frame_seen[0].xmx !== 11'd5 ||
                frame_seen[0].ymn !== 10'd1 || frame_seen[0].ymx !== 10'd3) begin
                errors++;
                $display("FAIL frame_bbox: %0d %0d %0d %0d required 2 5 1 3", frame_seen[0].xmn,
                         frame_seen[0].xmx, frame_seen[0].ymn, frame_seen[0].ymx);
            end
        end
        checks++;
        if (mask_seen.size() != 2 || exp_mask.size() != 2) begin
            errors++;
            $display("FAIL frame_masks: %0d words required 2", mask_seen.size());
        end else begin
            checks++;
            if (mask_seen[0] !== exp_mask[0] || mask_seen[1] !== exp_mask[1]) begin
                errors++;
                $display("FAIL frame_mask_words: %h %h required %h %h",
                         mask_seen[0], mask_seen[1], exp_mask[0], exp_mask[1]);
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (hit_count !== 20'd2 || x_max !== 11'd5) begin
            errors++;
            $display("FAIL frame_hold: hits=%0d x_max=%0d required 2 5", hit_count, x_max);
        end
    endtask

    task automatic test_empty_frame();
        for (int i = 0; i < H * V; i++) do_pixel(16'($urandom), 1'b0, $urandom_range(0, 3));
        repeat (2) @(negedge clk);
        checks++;
        if (frame_seen.size() != 2) begin
            errors++;
            $display("FAIL empty_count: %0d frames required 2", frame_seen.size());
        end else begin
            checks++;
            if (frame_seen[1].cnt !== 20'd0 || frame_seen[1].bv !== 1'b0) begin
                errors++;
                $display("FAIL empty_hits: count=%0d valid=%b required 0 0",
                         frame_seen[1].cnt, frame_seen[1].bv);
            end
            checks++;
            if (frame_seen[1].xmn !== 11'(H - 1) || frame_seen[1].xmx !== 11'd0 ||
                frame_seen[1].ymn !== 10'(V - 1) || frame_seen[1].ymx !== 10'd0) begin
                errors++;
                $display("FAIL empty_bbox: %0d %0d %0d %0d required %0d 0 %0d 0", frame_seen[1].xmn,
                         frame_seen[1].xmx, frame_seen[1].ymn, frame_seen[1].ymx, H - 1, V - 1);
            end
        end
    endtask

    task automatic test_random_frames();
        exp_mask.delete();
        exp_frame.delete();
        mask_seen.delete();
        frame_seen.delete();
        for (int i = 0; i < 2 * H * V; i++) begin
            do_pixel(16'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 8));
        end
        repeat (2) @(negedge clk);
        checks++;
        if (mask_seen.size() != exp_mask.size() || frame_seen.size() != exp_frame.size()) begin
            errors++;
            $display("FAIL rand_counts: masks=%0d frames=%0d required %0d %0d", mask_seen.size(),
                     frame_seen.size(), exp_mask.size(), exp_frame.size());
        end else begin
            foreach (exp_mask[i]) begin
                checks++;
                if (mask_seen[i] !== exp_mask[i]) begin
                    errors++;
                    $display("FAIL rand_mask[%0d]: %h required %h", i, mask_seen[i], exp_mask[i]);
                end
            end
            foreach (exp_frame[i]) begin
                checks++;
                if (frame_seen[i] != exp_frame[i]) begin
                    errors++;
                    $display("FAIL rand_frame[%0d]: cnt=%0d bv=%b box=%0d,%0d,%0d,%0d required cnt=%0d bv=%b box=%0d,%0d,%0d,%0d",
                             i, frame_seen[i].cnt, frame_seen[i].bv, frame_seen[i].xmn,
                             frame_seen[i].xmx, frame_seen[i].ymn, frame_seen[i].ymx,
                             exp_frame[i].cnt, exp_frame[i].bv, exp_frame[i].xmn,
                             exp_frame[i].xmx, exp_frame[i].ymn, exp_frame[i].ymx);
                end
            end
        end
    endtask

    task automatic test_reset_mid_handshake();
        int n;
        for (int i = 0; i < 3; i++) do_pixel(16'($urandom), 1'b1, 2);
        pix_data  = 16'hABCD;
        pix_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_out && n < BOUND);
        pix_valid = 1'b0;
        checks++;
        if (req_out !== 1'b1) begin
            errors++;
            $display("FAIL midrst_req: req_out=%b required 1", req_out);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (req_out !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: req_out=%b required 0 right after reset", req_out);
        end
        apply_reset();
        for (int i = 0; i < H * V; i++) do_pixel(16'($urandom), (i == 0), 1);
        repeat (2) @(negedge clk);
        checks++;
        if (frame_seen.size() != 1) begin
            errors++;
            $display("FAIL midrst_frames: %0d required 1", frame_seen.size());
        end else begin
            checks++;
            if (frame_seen[0].cnt !== 20'd1 || frame_seen[0].xmn !== 11'd0 ||
                frame_seen[0].xmx !== 11'd0 || frame_seen[0].ymn !== 10'd0 ||
                frame_seen[0].ymx !== 10'd0) begin
                errors++;
                $display("FAIL midrst_origin: cnt=%0d box=%0d,%0d,%0d,%0d required 1 0,0,0,0",
                         frame_seen[0].cnt, frame_seen[0].xmn, frame_seen[0].xmx,
                         frame_seen[0].ymn, frame_seen[0].ymx);
            end
        end
    endtask

`ifdef TIMEOUT_EN
    task automatic test_timeout();
        int n;
        int hi;
        apply_reset();
        pix_data  = 16'h1234;
        pix_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_out && n < BOUND);
        pix_valid = 1'b0;
        hi = 0;
        while (req_out && hi < BOUND) begin
            hi++;
            @(negedge clk);
        end
        checks++;
        if (hi != TCYC) begin
            errors++;
            $display("FAIL tmo_len: req_out high %0d cycles required %0d", hi, TCYC);
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_flag: timeout_err=%b required 1", timeout_err);
        end
        model_pixel(1'b0);
        for (int i = 1; i < H * V; i++) do_pixel(16'($urandom), (i == 1), 1);
        repeat (2) @(negedge clk);
        checks++;
        if (mask_seen.size() != 2 || mask_seen[0] !== 16'h0002) begin
            errors++;
            $display("FAIL tmo_bit: masks=%0d first=%h required 2 0002", mask_seen.size(),
                     mask_seen.size() > 0 ? mask_seen[0] : 16'hxxxx);
        end
        checks++;
        if (frame_seen.size() != 1 || frame_seen[0].cnt !== 20'd1 || frame_seen[0].xmn !== 11'd1) begin
            errors++;
            $display("FAIL tmo_frame: frames=%0d required 1 with count 1 at x=1", frame_seen.size());
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_sticky: timeout_err=%b required 1", timeout_err);
        end
    endtask
`else
    task automatic test_no_timeout();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_tied: timeout_err=%b required 0", timeout_err);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_pixel();
        test_mask();
        test_frame();
        test_empty_frame();
        test_random_frames();
        test_reset_mid_handshake();
`ifdef TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/color_filter_req_master.md
Name: color_filter_req_master

Overview:
- Initiator side of the four-phase req/ack pixel handshake used by the colour-threshold filter.
- Accepts RGB565 pixels from the camera capture stream and presents each one to the filter. Collects the filter's 1-bit match result per pixel.
- Packs results into 16-bit mask words. Per frame, accumulates the match count and bounding box for the downstream target-tracking logic.

Parameters:
- H_RES, 640, pixels per line; x wraps at H_RES-1.
- V_RES, 480, lines per frame; frame ends after pixel (H_RES-1, V_RES-1).
- TIMEOUT_CYC, 1024, clk cycles allowed per handshake phase (only with TIMEOUT_EN).

Ports:
- clk  in  1  50 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- pix_valid  in  1  upstream pixel valid
- pix_data  in  16  RGB565 pixel
- pix_ready  out  1  block can accept a pixel
- req_out  out  1  request to filter
- sensor_data  out  16  pixel held to filter, stable while req_out=1
- ack_in  in  1  filter acknowledge (asynchronous domain, synchronised internally)
- color_in  in  1  filter match bit, valid while ack_in=1
- mask_valid  out  1  one-cycle pulse, mask_word valid
- mask_word  out  16  16 match bits, bit0 = earliest pixel
- frame_done  out  1  one-cycle pulse after last pixel of frame
- hit_count  out  20  matches in completed frame
- bbox_valid  out  1  hit_count>0 for completed frame
- x_min, x_max  out  11  bounding box columns
- y_min, y_max  out  10  bounding box rows
- timeout_err  out  1  sticky handshake timeout flag (TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset: all outputs 0; state IDLE; x=y=0; bit index 0; accumulators cleared.
- ack_in passes through a 2-FF synchroniser (ack_s). color_in is sampled in the cycle ack_s is first seen high.
- FSM:
  - IDLE: pix_ready=1. On pix_valid, latch pix_data into sensor_data, assert req_out, go to WAIT_ACK_HI.
  - WAIT_ACK_HI: req_out=1. When ack_s=1, capture color_in, drop req_out, go to WAIT_ACK_LO.
  - WAIT_ACK_LO: when ack_s=0, run UPDATE, go to IDLE.
- pix_ready=1 only in IDLE. A new pixel is never accepted before ack from the previous pixel has fallen.
- Minimum cycle per pixel: 1 (IDLE) + sync latency + responder latency.
- UPDATE (single cycle):
  - Shift the captured bit into mask_word at the current bit index.
  - Index 15: pulse mask_valid with the complete word, reset index to 0.
  - If bit=1: increment the running count; update running min/max with the current x,y.
  - Advance x; at H_RES-1, wrap x to 0 and increment y.
- Frame end: at pixel (H_RES-1, V_RES-1), UPDATE also:
  - Copies running count and box to the output registers.
  - Sets bbox_valid = (count≠0) and pulses frame_done.
  - Resets running count=0, min to (H_RES-1, V_RES-1), max to (0,0), y=0.
  - A partial mask word at frame end is flushed with the unused high bits set to 0 (with the H_RES=640 default, 640x480 is a multiple of 16, so no partial word occurs).
- Output registers hold their values until the next frame_done.
- No hits in a frame: bbox_valid=0; x_min/x_max/y_min/y_max hold the reset sentinels (H_RES-1, 0, V_RES-1, 0).
- ack_s already high on entry to WAIT_ACK_HI (stale ack): treated as valid; the responder must not hold ack across requests.
- rst_n low mid-handshake: req_out drops immediately (asynchronous); the partial frame is discarded.
- hit_count saturates at 2^20-1.

Optional Feature:
- Macro: TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in WAIT_ACK_HI and in WAIT_ACK_LO and is cleared on state change.
  - Reaching TIMEOUT_CYC forces req_out=0 and sets sticky timeout_err (cleared only by reset).
  - The pixel is recorded as 0, the FSM returns to IDLE, and x/y still advance.
- Undefined: no counter; the FSM waits indefinitely; timeout_err tied 0.

Test Plan:
- Single pixel 0xF800 with a model responder returning ack after 5 cycles, color=1 -> sensor_data=0xF800 stable while req_out=1; req_out falls within 3 cycles of ack rise; pix_ready returns 1 only after ack falls.
- 16 pixels, responder color pattern 1010…, bit0 first -> one mask_valid pulse with mask_word=0x5555.
- Small frame (H_RES=8, V_RES=4), hits only at (2,1) and (5,3) -> frame_done once; hit_count=2; bbox_valid=1; x_min=2, x_max=5, y_min=1, y_max=3.
- Next frame with no hits -> bbox_valid=0, hit_count=0, previous box discarded.
- rst_n pulsed low while in WAIT_ACK_HI -> req_out=0 same cycle; after release, first accepted pixel is x=0,y=0.
- TIMEOUT_EN, TIMEOUT_CYC=20, responder never acks -> req_out drops after 20 cycles; timeout_err=1; next pixel accepted; bit recorded 0.
